tc21073_serial_add_8: RTL and testbench

TC21073_SERIAL_ADD_8 -- requirements
Module: tc21073_serial_add_8

---
 rtl/tc21073_serial_add_8.sv | 132 +++++++++++++
 tb/tb_tc21073_serial_add_8.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tc21073_serial_add_8.sv
// Bit-serial adder: one full-adder slice consumes one operand bit per clock,
// LSB first, producing sum, carry-out and signed overflow after WIDTH cycles.
module tc21073_serial_add_8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_co;

  // Single full-adder slice on the current LSBs and the carry flop.
  always_comb begin
    w_s  = r_a[0] ^ r_b[0] ^ r_c;
    w_co = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Operand shift registers, carry flop, bit counter and result shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_c   <= cin;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= {w_s, r_res[WIDTH-1:1]};
      r_c   <= w_co;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Visible results update only on the edge that finishes the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_sum  <= {w_s, r_res[WIDTH-1:1]};
      r_cout <= w_co;
      r_ovf  <= r_c ^ w_co;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_tc21073_serial_add_8.sv
// Directed bench for the bit-serial adder: vector table plus reset/abort and
// back-to-back sequences.
module tb_tc21073_serial_add_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  tc21073_serial_add_8 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one addition from a single start pulse and checks timing and results.
  task automatic run_op(input int idx, input vec_t v);
    int         k;
    int         busy_cnt;
    logic [7:0] prev_sum;
    logic       sum_moved;
    @(negedge clk);
    prev_sum = sum;
    start = 1'b1; a = v.a; b = v.b; cin = v.cin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
    k = 0; busy_cnt = 0; sum_moved = 1'b0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      if (sum !== prev_sum) sum_moved = 1'b1;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(k), 32'd8);
    chk($sformatf("v%0d_busy_cycles", idx), 32'(busy_cnt), 32'd8);
    chk($sformatf("v%0d_sum_stable_in_run", idx), 32'(sum_moved), 32'd0);
    chk($sformatf("v%0d_busy_in_done", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_sum", idx), 32'(sum), 32'(v.exp_sum));
    chk($sformatf("v%0d_cout", idx), 32'(cout), 32'(v.exp_cout));
    chk($sformatf("v%0d_ovf", idx), 32'(ovf), 32'(v.exp_ovf));
    @(negedge clk);
    chk($sformatf("v%0d_done_one_cycle", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d_sum_held", idx), 32'(sum), 32'(v.exp_sum));
  endtask

  initial begin
    int t;
    int t1;
    int t2;
    int seen_done;
    int seen_busy;
    logic sum_moved;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf",  32'(ovf),  32'd0);

    for (int i = 0; i < 9; i++) run_op(i, vecs[i]);

    // Abort: restart attempt in RUN is ignored, reset mid-run kills the op.
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    start = 1'b1; a = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_after_restart", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf",  32'(ovf),  32'd0);
    seen_done = 0; seen_busy = 0;
    repeat (15) begin
      @(posedge clk); @(negedge clk);
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    chk("abort_no_done_pulse", 32'(seen_done), 32'd0);
    chk("abort_stays_idle", 32'(seen_busy), 32'd0);

    // Reset and start on the same edge: start must not be accepted.
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_start_still_idle", 32'(busy), 32'd0);

    // Held start: back-to-back operations every 10 clocks.
    t = 0; t1 = -1; t2 = -1; sum_moved = 1'b0;
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 8'h02; b = 8'h02;
    while (t < 40 && t2 < 0) begin
      if (done && t1 < 0) begin
        t1 = t;
        chk("b2b_first_sum", 32'(sum), 32'h02);
      end else if (done) begin
        t2 = t;
        chk("b2b_second_sum", 32'(sum), 32'h04);
      end else if (t1 >= 0 && busy && sum !== 8'h02) begin
        sum_moved = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk("b2b_first_latency", 32'(t1), 32'd8);
    chk("b2b_spacing", 32'(t2 - t1), 32'd10);
    chk("b2b_sum_stable_in_run", 32'(sum_moved), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
